// File: rtl/matmul_pkg.sv
// Shared types and parameter helpers for the tile dot-product engine.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    COMPUTE,
    DRAIN,
    DONE
  } state_t;

  // Full-precision product plus enough headroom to sum k_max of them.
  function automatic int calc_acc_w(input int data_w, input int k_max);
    return 2 * data_w + $clog2(k_max);
  endfunction

endpackage

// File: rtl/matmul_tile_engine_if.sv
// Operand-in / result-out stream bundle of the tile engine.
interface matmul_tile_engine_if
  import matmul_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = calc_acc_w(8, 64)
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out;
  logic              out_last;

  // The producer/consumer side drives operands and accepts results.
  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, out, out_last
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, out, out_last
  );

endinterface

// File: rtl/mac_unit.sv
// Two-stage multiply-accumulate: registered product, then wrap-around accumulation.
module mac_unit
  import matmul_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K_MAX  = 64,
  parameter int ACC_W  = calc_acc_w(DATA_W, K_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic        [ACC_W-1:0]    prod_ext;
  logic        [ACC_W-1:0]    prod_q;
  logic                       prod_vld;

  // Operands are widened first so the multiply itself is full precision.
  always_comb begin
    prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    if (is_signed) begin
      prod_ext = ACC_W'(prod_s);
    end else begin
      prod_ext = ACC_W'(prod_u);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q   <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else if (clear) begin
      prod_q   <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= load;
      if (load) begin
        prod_q <= prod_ext;
      end
      if (prod_vld) begin
        acc <= acc + prod_q;
      end
    end
  end

endmodule

// File: rtl/matmul_tile_engine.sv
// Streams cfg_k operand pairs per output and emits cfg_n dot products per job.
module matmul_tile_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K_MAX  = 64,
  parameter int N_MAX  = 16,
  parameter int ACC_W  = calc_acc_w(DATA_W, K_MAX)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ebl,
  input  logic [$clog2(K_MAX+1)-1:0] cfg_k,
  input  logic [$clog2(N_MAX+1)-1:0] cfg_n,
  input  logic                       cfg_signed,
  output logic                       busy,
  output logic                       cfg_err,
  matmul_tile_engine_if.slave        bus
);

  localparam int KW = $clog2(K_MAX + 1);
  localparam int NW = $clog2(N_MAX + 1);

  state_t          state;
  state_t          state_nxt;
  logic [KW-1:0]   k_cfg;
  logic [NW-1:0]   n_cfg;
  logic            signed_cfg;
  logic [KW-1:0]   pair_cnt;
  logic [NW-1:0]   out_cnt;
  logic            drain_cnt;
  logic            start_ok;
  logic            pair_fire;
  logic            last_pair;
  logic            last_out;
  logic            out_take;
  logic            mac_clear;
  logic [ACC_W-1:0] acc;

  always_comb begin
    start_ok  = ebl && (cfg_k != '0) && (cfg_k <= KW'(K_MAX)) &&
                (cfg_n != '0) && (cfg_n <= NW'(N_MAX));
    pair_fire = (state == COMPUTE) && bus.in_valid;
    last_pair = (pair_cnt == k_cfg - KW'(1));
    last_out  = (out_cnt == n_cfg - NW'(1));
    out_take  = (state == DONE) && bus.out_ready;
    mac_clear = (state == FILL) || (out_take && !last_out);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b1;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out       = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        state_nxt = COMPUTE;
      end
      COMPUTE: begin
        bus.in_ready = 1'b1;
        if (pair_fire && last_pair) begin
          state_nxt = DRAIN;
        end
      end
      // Two cycles let the final product pass through both MAC stages.
      DRAIN: begin
        if (drain_cnt) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_out;
        bus.out       = acc;
        if (bus.out_ready) begin
          state_nxt = last_out ? IDLE : COMPUTE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_cfg      <= '0;
      n_cfg      <= '0;
      signed_cfg <= 1'b0;
      pair_cnt   <= '0;
      out_cnt    <= '0;
      drain_cnt  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && ebl && !start_ok;
      if ((state == IDLE) && start_ok) begin
        k_cfg      <= cfg_k;
        n_cfg      <= cfg_n;
        signed_cfg <= cfg_signed;
      end
      if (state == FILL) begin
        pair_cnt <= '0;
        out_cnt  <= '0;
      end else if (pair_fire) begin
        pair_cnt <= pair_cnt + KW'(1);
      end else if (out_take && !last_out) begin
        pair_cnt <= '0;
        out_cnt  <= out_cnt + NW'(1);
      end
      drain_cnt <= (state == DRAIN) ? !drain_cnt : 1'b0;
    end
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .K_MAX  (K_MAX),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clear     (mac_clear),
    .load      (pair_fire),
    .is_signed (signed_cfg),
    .a         (bus.a_in),
    .b         (bus.b_in),
    .acc       (acc)
  );

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Directed self-checking bench for matmul_tile_engine with hand-computed results.
module tb_matmul_tile_engine;

  localparam int DATA_W = 8;
  localparam int K_MAX  = 64;
  localparam int N_MAX  = 16;
  localparam int ACC_W  = 22;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ebl = 1'b0;
  logic [6:0] cfg_k = '0;
  logic [4:0] cfg_n = '0;
  logic       cfg_signed = 1'b0;
  logic       busy;
  logic       cfg_err;
  int         checks = 0;
  int         errors = 0;

  matmul_tile_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  matmul_tile_engine #(
    .DATA_W (DATA_W),
    .K_MAX  (K_MAX),
    .N_MAX  (N_MAX),
    .ACC_W  (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ebl        (ebl),
    .cfg_k      (cfg_k),
    .cfg_n      (cfg_n),
    .cfg_signed (cfg_signed),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [6:0] k, input logic [4:0] n, input logic sgn);
    cfg_k = k;
    cfg_n = n;
    cfg_signed = sgn;
    ebl = 1'b1;
    step();
    ebl = 1'b0;
    step();
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.a_in = a;
    bus.b_in = b;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL feed_timeout: in_ready got 0 expected 1");
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL out_timeout: out_valid got 0 expected 1");
    end
  endtask

  task automatic take_out();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_last: got %b expected 0", bus.out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_cfg_err: got %b expected 0", cfg_err); end
    checks++; if (bus.out !== 22'd0) begin errors++; $display("[TB] FAIL rst_out: got %0d expected 0", bus.out); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_unsigned_basic();
    logic [7:0] av [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
    logic [7:0] bv [4] = '{8'd2, 8'd4, 8'd6, 8'd8};
    cfg_k = 7'd4; cfg_n = 5'd1; cfg_signed = 1'b0; ebl = 1'b1;
    step();
    ebl = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL fill_busy: got %b expected 1", busy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_in_ready: got %b expected 0", bus.in_ready); end
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL compute_in_ready: got %b expected 1", bus.in_ready); end
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.a_in = av[i]; bus.b_in = bv[i];
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL drain_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat_t1: out_valid got %b expected 0", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat_t2: out_valid got %b expected 0", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL lat_t3: out_valid got %b expected 1", bus.out_valid); end
    checks++; if (bus.out !== 22'd100) begin errors++; $display("[TB] FAIL basic_out: got %0d expected 100", bus.out); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("[TB] FAIL basic_last: got %b expected 1", bus.out_last); end
    take_out();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: busy got %b expected 0", busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_signed();
    start_job(7'd2, 5'd1, 1'b1);
    feed(8'hFD, 8'h05);
    feed(8'h80, 8'h80);
    wait_out();
    checks++; if (bus.out !== 22'd16369) begin errors++; $display("[TB] FAIL signed_out: got %0d expected 16369", bus.out); end
    take_out();
    start_job(7'd2, 5'd1, 1'b0);
    feed(8'hFD, 8'h05);
    feed(8'h80, 8'h80);
    wait_out();
    checks++; if (bus.out !== 22'd17649) begin errors++; $display("[TB] FAIL unsigned_bits_out: got %0d expected 17649", bus.out); end
    take_out();
  endtask

  task automatic test_gaps();
    start_job(7'd3, 5'd1, 1'b0);
    feed(8'd2, 8'd3);
    step(); step(); step();
    feed(8'd4, 8'd5);
    step();
    feed(8'd6, 8'd7);
    wait_out();
    checks++; if (bus.out !== 22'd68) begin errors++; $display("[TB] FAIL gaps_out: got %0d expected 68", bus.out); end
    take_out();
  endtask

  task automatic test_back_to_back();
    start_job(7'd2, 5'd3, 1'b0);
    for (int r = 0; r < 3; r++) begin
      feed(8'd1, 8'd1);
      feed(8'd1, 8'd1);
      wait_out();
      checks++; if (bus.out !== 22'd2) begin errors++; $display("[TB] FAIL multi_out_%0d: got %0d expected 2", r, bus.out); end
      checks++; if (bus.out_last !== (r == 2)) begin errors++; $display("[TB] FAIL multi_last_%0d: got %b expected %b", r, bus.out_last, (r == 2)); end
      if (r == 1) begin
        for (int s = 0; s < 5; s++) begin
          ebl = 1'b1; cfg_k = 7'd0; bus.in_valid = 1'b1; bus.a_in = 8'd9; bus.b_in = 8'd9;
          checks++; if (bus.out_valid !== 1'b1 || bus.out !== 22'd2) begin errors++; $display("[TB] FAIL stall_hold_%0d: valid %b out %0d expected 1 and 2", s, bus.out_valid, bus.out); end
          checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready_%0d: got %b expected 0", s, bus.in_ready); end
          checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL stall_cfg_err_%0d: got %b expected 0", s, cfg_err); end
          step();
        end
        ebl = 1'b0; bus.in_valid = 1'b0;
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL ebl_ignored: cfg_err got %b expected 0", cfg_err); end
      end
      take_out();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL multi_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_cfg_err();
    logic [6:0] kv [3] = '{7'd0, 7'd65, 7'd4};
    logic [4:0] nv [3] = '{5'd1, 5'd1, 5'd17};
    for (int i = 0; i < 3; i++) begin
      cfg_k = kv[i]; cfg_n = nv[i]; ebl = 1'b1;
      step();
      ebl = 1'b0;
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL cfg_err_pulse_%0d: got %b expected 1", i, cfg_err); end
      checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL cfg_err_idle_%0d: busy %b in_ready %b expected 0 0", i, busy, bus.in_ready); end
      step();
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL cfg_err_width_%0d: got %b expected 0", i, cfg_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cfg_err_busy_%0d: got %b expected 0", i, busy); end
    end
  endtask

  task automatic test_kmax();
    start_job(7'd64, 5'd1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      feed(8'd255, 8'd255);
    end
    wait_out();
    checks++; if (bus.out !== 22'd4161600) begin errors++; $display("[TB] FAIL kmax_out: got %0d expected 4161600", bus.out); end
    take_out();
  endtask

  task automatic test_reset_mid_job();
    start_job(7'd4, 5'd1, 1'b0);
    feed(8'd10, 8'd10);
    feed(8'd10, 8'd10);
    rst = 1'b1;
    #2;
    checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL async_rst: busy %b in_ready %b expected 0 0", busy, bus.in_ready); end
    step();
    rst = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_idle: busy got %b expected 0", busy); end
    start_job(7'd1, 5'd1, 1'b0);
    feed(8'd2, 8'd3);
    wait_out();
    checks++; if (bus.out !== 22'd6) begin errors++; $display("[TB] FAIL post_rst_out: got %0d expected 6", bus.out); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_last: got %b expected 1", bus.out_last); end
    take_out();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_gaps();
    test_back_to_back();
    test_cfg_err();
    test_kmax();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_tile_engine.md
MATMUL_TILE_ENGINE -- requirements
Module: matmul_tile_engine

Interface
REQ-001 Parameter DATA_W, default 8, operand width in bits.
REQ-002 Parameter K_MAX, default 64, maximum dot-product length.
REQ-003 Parameter N_MAX, default 16, maximum outputs per job.
REQ-004 Parameter ACC_W, default 2*DATA_W+$clog2(K_MAX), accumulator/result width.
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ebl  in  1  job start; sampled only in IDLE.
REQ-008 cfg_k  in  $clog2(K_MAX+1)  pairs per output; sampled in IDLE when ebl=1.
REQ-009 cfg_n  in  $clog2(N_MAX+1)  outputs per job; sampled in IDLE when ebl=1.
REQ-010 cfg_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled in IDLE when ebl=1.
REQ-011 in_valid  in  1  operand pair valid.
REQ-012 in_ready  out  1  engine accepts pair.
REQ-013 a_in  in  DATA_W  operand A.
REQ-014 b_in  in  DATA_W  operand B.
REQ-015 out_valid  out  1  result valid.
REQ-016 out_ready  in  1  consumer accepts result.
REQ-017 out  out  ACC_W  dot-product result.
REQ-018 out_last  out  1  qualifies the final result of the job.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 cfg_err  out  1  one-cycle pulse on a rejected start.

Function
REQ-021 State machine SHALL have states IDLE, FILL, COMPUTE, DRAIN, DONE.
REQ-022 IDLE->FILL when ebl=1 and 1<=cfg_k<=K_MAX and 1<=cfg_n<=N_MAX; config latched in that cycle.
REQ-023 ebl=1 with any cfg out of range SHALL stay in IDLE and pulse cfg_err for exactly 1 cycle.
REQ-024 FILL SHALL last exactly 1 cycle: clear accumulator, pair counter and output counter, then go to COMPUTE.
REQ-025 in_ready SHALL be 1 only in COMPUTE; a pair is accepted when in_valid and in_ready are both 1.
REQ-026 An accepted pair SHALL be multiplied into a product register (stage 1); the next cycle adds it to the accumulator (stage 2).
REQ-027 Products SHALL be signed or unsigned per the latched cfg_signed and sign- or zero-extended to ACC_W before accumulation.
REQ-028 Accumulation SHALL wrap modulo 2^ACC_W; no saturation.
REQ-029 The cfg_k-th accepted pair SHALL move COMPUTE->DRAIN; in_ready deasserts in the next cycle.
REQ-030 DRAIN SHALL last exactly 2 cycles, then go to DONE.
REQ-031 Last pair accepted at cycle t SHALL give out_valid=1 at cycle t+3.
REQ-032 In DONE, out, out_valid and out_last SHALL hold stable until out_ready=1.
REQ-033 out_last SHALL be 1 only when the output counter equals cfg_n-1.
REQ-034 DONE with out_ready=1: if not last, clear accumulator and pair counter, increment output counter, go to COMPUTE; if last, go to IDLE.
REQ-035 No pair SHALL be accepted while out_valid=1.
REQ-036 ebl SHALL be ignored outside IDLE.
REQ-037 in_valid=0 gaps in COMPUTE SHALL stall the computation without corrupting the accumulator.

Reset
REQ-038 rst=1 SHALL asynchronously force IDLE and clear all counters, the product register, the accumulator and the latched config.
REQ-039 During reset: in_ready=0, out_valid=0, out_last=0, busy=0, cfg_err=0, out=0.
REQ-040 Reset mid-job SHALL discard the partial result; after release the engine waits in IDLE for a new ebl.

Structure
REQ-041 Package matmul_pkg SHALL hold state_t (IDLE, FILL, COMPUTE, DRAIN, DONE) and the ACC_W derivation function.
REQ-042 Sub-module mac_unit SHALL contain the product register, extension logic and accumulator, with clear and enable inputs from the FSM.

Verification
REQ-043 Unsigned run, cfg_k=4, cfg_n=1, pairs (1,2)(3,4)(5,6)(7,8), no gaps -> out=100 with out_last=1 at t+3; then IDLE.
REQ-044 Signed run, cfg_k=2, pairs (-3,5)(-128,-128) -> out=16369 (-15+16384); unsigned mode on the same bits -> 253*5+128*128=17649.
REQ-045 cfg_n=3, cfg_k=2, all pairs (1,1), out_ready held 0 for 5 cycles on result 2 -> three results of 2, out held stable while stalled, out_last only on the third.
REQ-046 ebl with cfg_k=0 or cfg_k=K_MAX+1 -> one-cycle cfg_err pulse, busy stays 0, in_ready stays 0.
REQ-047 K_MAX pairs of (255,255) unsigned -> out=K_MAX*65025 with no overflow at the default ACC_W.
REQ-048 rst asserted after 2 of 4 pairs, then a new job cfg_k=1 with pair (2,3) -> out=6 with no residue from the aborted job.
